// File: rtl/disp_pkg.sv
// Shared definitions for the 4-digit display scan controller.
//   DISP_DIGITS / SCAN_W : number of multiplexed digits and width of the scan index
//   PT_OFF / LE_OFF      : reset (all-off) patterns for the active-low points and enables
//   *_DEF                : default prescaler settings (2 kHz digit rate at 100 MHz)
//   disp_word_t          : one complete display word (nibbles, points, enables)
//   upd_state_t          : state of the update handshake
package disp_pkg;

  localparam int DISP_DIGITS = 4;
  localparam int SCAN_W      = 2;

  localparam logic [DISP_DIGITS-1:0] PT_OFF = 4'hF;
  localparam logic [DISP_DIGITS-1:0] LE_OFF = 4'hF;

  localparam int DIV_W_DEF     = 16;
  localparam int DIV_TERM_DEF  = 49999;
  localparam int BLANK_CYC_DEF = 100;

  typedef struct packed {
    logic [4*DISP_DIGITS-1:0] hexs;
    logic [DISP_DIGITS-1:0]   point;
    logic [DISP_DIGITS-1:0]   les;
  } disp_word_t;

  localparam disp_word_t WORD_RESET = '{hexs: '0, point: PT_OFF, les: LE_OFF};

  // IDLE: no word waiting (ready). PENDING: a word waits for the next frame boundary.
  typedef enum logic {
    UPD_IDLE    = 1'b0,
    UPD_PENDING = 1'b1
  } upd_state_t;

endpackage

// File: rtl/disp_prescaler.sv
// Digit-slot prescaler: divides clk into slots of DIV_TERM+1 cycles and
// produces the inter-digit blanking strobe.
//   clk, rst : clock, asynchronous active-high reset
//   en       : 1 = count, 0 = freeze count and force blank
//   tick     : combinational, high in the last cycle of a slot (slot ends at this edge)
//   blank    : registered, high for the first BLANK_CYC cycles of every slot or while en=0
module disp_prescaler #(
  parameter int DIV_W     = 16,
  parameter int DIV_TERM  = 49999,
  parameter int BLANK_CYC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic blank
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;

  assign tick = en & (cnt == DIV_W'(DIV_TERM));

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_next = cnt;
    if (en) cnt_next = tick ? '0 : cnt + DIV_W'(1);
  end

  // blank is evaluated on the next-state count so it rises together with the
  // scan change rather than one cycle after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      blank <= 1'b1;
    end else begin
      cnt   <= cnt_next;
      blank <= ~en | (cnt_next < DIV_W'(BLANK_CYC));
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Upstream driver of the 4-digit display multiplexer.
// Generates the digit scan index, holds the displayed word in shadow registers
// that only change at frame boundaries (Scan 3->0), and accepts new words from
// game logic through a valid/ready handshake with a single pending buffer.
//   clk, rst          : clock, asynchronous active-high reset
//   en                : 1 = scanning runs, 0 = scan frozen and blank forced
//   upd_valid/ready   : word handshake; ready is low while a word is pending
//   upd_hexs/point/les: offered word (nibble i = digit i, points/enables active-low)
//   Hexs/Point/Les    : shadow word presented to the multiplexer
//   Scan              : current digit index
//   blank             : 1 = downstream drives all anodes off
//   frame_start       : one-cycle pulse in the cycle Scan becomes 0 after 3
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int DIV_TERM  = DIV_TERM_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [4*DISP_DIGITS-1:0] upd_hexs,
  input  logic [DISP_DIGITS-1:0]   upd_point,
  input  logic [DISP_DIGITS-1:0]   upd_les,
  output logic [4*DISP_DIGITS-1:0] Hexs,
  output logic [DISP_DIGITS-1:0]   Point,
  output logic [DISP_DIGITS-1:0]   Les,
  output logic [SCAN_W-1:0]        Scan,
  output logic                     blank,
  output logic                     frame_start
);

  logic       tick;
  logic       frame_edge;
  upd_state_t state;
  disp_word_t pend_word;
  disp_word_t shown;

  disp_prescaler #(
    .DIV_W    (DIV_W),
    .DIV_TERM (DIV_TERM),
    .BLANK_CYC(BLANK_CYC)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick),
    .blank(blank)
  );

  // The edge at which the last digit's slot ends is the frame boundary.
  assign frame_edge = tick & (Scan == SCAN_W'(DISP_DIGITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Scan        <= '0;
      frame_start <= 1'b0;
      state       <= UPD_IDLE;
      upd_ready   <= 1'b1;
      // NOTE: the pending buffer is reset as well, so a word discarded by
      // reset can never surface at a later boundary.
      pend_word   <= WORD_RESET;
      shown       <= WORD_RESET;
    end else begin
      if (tick) Scan <= Scan + SCAN_W'(1);
      frame_start <= frame_edge;

      // A word accepted in a boundary cycle is only captured here; it commits
      // at the following boundary because the commit needs PENDING beforehand.
      unique case (state)
        UPD_IDLE: begin
          if (upd_valid) begin
            pend_word <= '{hexs: upd_hexs, point: upd_point, les: upd_les};
            state     <= UPD_PENDING;
            upd_ready <= 1'b0;
          end
        end
        UPD_PENDING: begin
          if (frame_edge) begin
            shown     <= pend_word;
            state     <= UPD_IDLE;
            upd_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign Hexs  = shown.hexs;
  assign Point = shown.point;
  assign Les   = shown.les;

endmodule
